rr_mux_nx1: RTL and testbench
=============================

Name: rr_mux_nx1

Overview:
- Round-robin N:1 stream multiplexer. It merges N valid/ready input channels onto one registered output stream.
- It tags each output word with its source channel index, so a downstream 1xN demux can route the word back using that index as its select.
- It is the collecting end of the demux fabric, sitting between the per-channel producers and the shared link.

Parameters:
- N, 4, number of input channels (2..16).
- W, 8, data width per channel.
- SW, $clog2(N), width of the channel index (derived; not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  N*W  channel k occupies bits [k*W +: W].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready. At most one bit is high in any cycle.
- out_data  output  W  registered data.
- out_sel  output  SW  registered source channel index of out_data.
- out_valid  output  1  registered valid.
- out_ready  input  1  downstream ready.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_data=0, out_sel=0.
  - Round-robin pointer ptr=0.
  - in_ready is forced to 0 while rst_n is low.
- Output register states:
  - EMPTY, encoded as out_valid=0.
  - FULL, encoded as out_valid=1.
- Load condition: load = !out_valid | out_ready (the register is empty, or it drains this cycle).
- Grant search (combinational):
  - Search in_valid starting at index ptr, ascending and wrapping modulo N.
  - The first asserted channel g wins.
  - If no in_valid bit is set, there is no grant.
- Handshake timing:
  - in_ready[g] = load & grant_found. All other in_ready bits are 0.
  - in_ready may depend combinationally on in_valid and out_ready; this is documented.
  - Transfer on input k occurs when in_valid[k] & in_ready[k].
- On a transfer from channel g at a clock edge:
  - out_data <= in_data[g], out_sel <= g, out_valid <= 1.
  - ptr <= (g+1) mod N, with explicit wrap. Non-power-of-2 N must wrap at N-1 to 0.
- No transfer, but out_valid & out_ready: out_valid <= 0. out_data and out_sel hold their last values.
- No transfer and out_ready=0: all registers hold.
- ptr changes only on a transfer.
- Latency: one cycle from input transfer to out_valid.
- Throughput: one word per cycle while out_ready=1 and any input is valid. Simultaneous drain and load in the same cycle is required; no bubble is allowed.
- Fairness:
  - With all N channels continuously valid and out_ready=1, grants cycle 0,1,..,N-1,0,...
  - Any continuously valid channel is granted within N transfers.
- Producer contract:
  - Data on a channel must stay stable while its valid is high and it has not yet transferred.
  - A producer may withdraw valid before transfer. The block does not latch requests.
- Output contract:
  - While out_valid=1 and out_ready=0, out_data and out_sel stay stable (AXI-style).
- Single-channel case: only one channel valid means it is granted every load cycle regardless of ptr.
- Reset mid-operation: a word held in the output register is discarded. out_valid drops asynchronously.

Decomposition:
- Shared package (mux_pkg):
  - Constant function clog2.
  - Typedef for channel-index width.
  - Both are reused by the matching demux for the out_sel/select width.
- One natural sub-module: rr_arbiter (parameter N).
  - Inputs: req[N], ptr.
  - Outputs: one-hot gnt[N], gnt_idx, found.
  - Purely combinational, implemented as a double-width masked priority search.
  - The top level owns ptr, the output register and the data select.

Test Plan:
1. Reset, then release:
   - Required: out_valid=0 and in_ready=0 during reset.
   - Then drive in_valid=4'b0100, in_data ch2=8'hA5, out_ready=1.
   - Required: next cycle out_valid=1, out_data=8'hA5, out_sel=2, and ptr becomes 3.
2. All four channels valid continuously, data ch k = 8'h10+k, out_ready=1 for 8 cycles:
   - Required: out_sel sequence 0,1,2,3,0,1,2,3.
   - Required: one word per cycle, no bubbles.
3. Backpressure:
   - Load ch1=8'h3C, then set out_ready=0 for 5 cycles with ch0 and ch3 valid.
   - Required: out_data=8'h3C and out_sel=1 hold, and in_ready=0.
   - Then set out_ready=1. Required: ch3 is granted next (ptr=2 searches 2, then 3), then ch0.
4. Wrap:
   - N=3 build. Channels 1 and 2 are granted, then only ch0 is valid.
   - Required: ch0 is granted and ptr returns to 1. Check ptr never reaches 3.
5. Idle drain:
   - out_valid=1, out_ready=1, no inputs valid.
   - Required: out_valid=0 next cycle, and out_sel/out_data hold their last values.
6. Reset mid-stream:
   - Assert rst_n=0 asynchronously (between edges) while out_valid=1 and out_ready=0.
   - Required: out_valid=0 immediately.
   - After release with all channels valid, the first grant is channel 0.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the round-robin mux / demux fabric.
// The helpers below size the channel-index (select) field.
package mux_pkg;

  localparam int unsigned DEF_N = 4;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  localparam int unsigned DEF_SW = clog2(DEF_N);

  typedef logic [DEF_SW-1:0] chan_idx_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr wins,
// wrapping modulo N, via a double-width masked priority search.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [clog2(N)-1:0]  ptr,
  output logic [N-1:0]         gnt,
  output logic [clog2(N)-1:0]  gnt_idx,
  output logic                 found
);

  localparam int unsigned SW = clog2(N);
  localparam int unsigned PW = clog2(2 * N);

  logic [N-1:0]   w_mask;
  logic [2*N-1:0] w_dbl;
  logic [PW-1:0]  w_pos;

  always_comb begin
    w_mask = '0;
    for (int k = 0; k < int'(N); k++) begin
      w_mask[k] = (32'(k) >= 32'(ptr));
    end
  end

  // Lower half holds requests at/above ptr; upper half is the wrapped copy.
  assign w_dbl = {req, req & w_mask};

  always_comb begin
    w_pos = '0;
    found = 1'b0;
    for (int j = 2 * int'(N) - 1; j >= 0; j--) begin
      if (w_dbl[j]) begin
        w_pos = PW'(j);
        found = 1'b1;
      end
    end
  end

  assign gnt_idx = (w_pos >= PW'(N)) ? SW'(w_pos - PW'(N)) : SW'(w_pos);
  assign gnt     = found ? (N'(1) << gnt_idx) : '0;

endmodule

// File: rtl/rr_mux_nx1.sv
// Round-robin N:1 valid/ready stream mux with a registered, channel-tagged
// output stage. Drain and reload can happen in the same cycle.
module rr_mux_nx1
  import mux_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*W-1:0]       in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  output logic [W-1:0]         out_data,
  output logic [clog2(N)-1:0]  out_sel,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int unsigned SW = clog2(N);

  logic [SW-1:0] r_ptr;
  logic [W-1:0]  r_out_data;
  logic [SW-1:0] r_out_sel;
  logic          r_out_valid;

  logic [N-1:0]  w_gnt;
  logic [SW-1:0] w_idx;
  logic          w_found;
  logic          w_load;
  logic          w_xfer;
  logic [SW-1:0] w_ptr_nxt;

  rr_arbiter #(.N(N)) u_arb (
    .req     (in_valid),
    .ptr     (r_ptr),
    .gnt     (w_gnt),
    .gnt_idx (w_idx),
    .found   (w_found)
  );

  assign w_load    = !r_out_valid || out_ready;
  assign w_xfer    = w_load && w_found;
  assign w_ptr_nxt = (w_idx == SW'(N - 1)) ? '0 : SW'(w_idx + SW'(1));

  // Ready is held low throughout reset so no producer sees a phantom accept.
  assign in_ready = rst_n ? (w_gnt & {N{w_load}}) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_out_valid <= 1'b0;
    end else if (w_xfer) begin
      r_out_data  <= in_data[w_idx*W +: W];
      r_out_sel   <= w_idx;
      r_out_valid <= 1'b1;
      r_ptr       <= w_ptr_nxt;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_rr_mux_nx1.sv
// Directed self-checking bench for rr_mux_nx1 (N=4 instance plus an N=3
// instance for the non-power-of-two wrap).
module tb_rr_mux_nx1;

  logic        clk;
  logic        rst_n;

  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_valid;
  logic        out_ready;

  logic [23:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [7:0]  out_data3;
  logic [1:0]  out_sel3;
  logic        out_valid3;
  logic        out_ready3;

  int n_cmp;
  int n_err;

  rr_mux_nx1 #(.N(4), .W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  rr_mux_nx1 #(.N(3), .W(8)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .out_data  (out_data3),
    .out_sel   (out_sel3),
    .out_valid (out_valid3),
    .out_ready (out_ready3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    in_data    = '0;
    in_valid   = '0;
    out_ready  = 1'b1;
    in_data3   = {8'h22, 8'h21, 8'h20};
    in_valid3  = '0;
    out_ready3 = 1'b1;

    // 1: reset, then single channel 2
    in_valid = 4'b0100;
    in_data  = {8'h00, 8'hA5, 8'h00, 8'h00};
    step();
    step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("t1_in_ready", 32'(in_ready), 32'h4);
    step();
    chk("t1_out_valid", 32'(out_valid), 32'd1);
    chk("t1_out_data", 32'(out_data), 32'hA5);
    chk("t1_out_sel", 32'(out_sel), 32'd2);
    chk("t1_ptr", 32'(dut.r_ptr), 32'd3);

    // Bring ptr back to 0 by granting ch3 alone.
    in_valid = 4'b1000;
    in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    step();
    chk("t1b_sel", 32'(out_sel), 32'd3);
    chk("t1b_ptr", 32'(dut.r_ptr), 32'd0);

    // 2: all valid, full throughput
    in_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("t2_valid_%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("t2_sel_%0d", i), 32'(out_sel), 32'(i % 4));
      chk($sformatf("t2_data_%0d", i), 32'(out_data), 32'(8'h10 + i % 4));
    end

    // 3: backpressure
    in_valid = 4'b0010;
    in_data  = {8'h53, 8'h00, 8'h3C, 8'h50};
    step();
    chk("t3_load_sel", 32'(out_sel), 32'd1);
    chk("t3_ptr", 32'(dut.r_ptr), 32'd2);
    in_valid  = 4'b1001;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("t3_in_ready_%0d", i), 32'(in_ready), 32'd0);
      step();
      chk($sformatf("t3_hold_data_%0d", i), 32'(out_data), 32'h3C);
      chk($sformatf("t3_hold_sel_%0d", i), 32'(out_sel), 32'd1);
      chk($sformatf("t3_hold_valid_%0d", i), 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("t3_in_ready_rel", 32'(in_ready), 32'h8);
    step();
    chk("t3_sel_a", 32'(out_sel), 32'd3);
    chk("t3_data_a", 32'(out_data), 32'h53);
    step();
    chk("t3_sel_b", 32'(out_sel), 32'd0);
    chk("t3_data_b", 32'(out_data), 32'h50);

    // 5: idle drain
    in_valid = 4'b0000;
    step();
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_sel_hold", 32'(out_sel), 32'd0);
    chk("t5_data_hold", 32'(out_data), 32'h50);

    // 6: reset mid-stream while stalled
    in_valid  = 4'b0010;
    in_data   = {8'h00, 8'h00, 8'h77, 8'h00};
    out_ready = 1'b0;
    step();
    in_valid = 4'b0000;
    chk("t6_loaded", 32'(out_valid), 32'd1);
    chk("t6_loaded_sel", 32'(out_sel), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 32'(out_valid), 32'd0);
    chk("t6_async_ready", 32'(in_ready), 32'd0);
    step();
    rst_n     = 1'b1;
    in_valid  = 4'b1111;
    in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
    out_ready = 1'b1;
    #1;
    chk("t6_first_ready", 32'(in_ready), 32'h1);
    step();
    chk("t6_first_sel", 32'(out_sel), 32'd0);
    chk("t6_first_data", 32'(out_data), 32'h10);
    in_valid = 4'b0000;

    // 4: N=3 wrap
    in_valid3 = 3'b110;
    step();
    chk("t4_sel_1", 32'(out_sel3), 32'd1);
    chk("t4_ptr_1", 32'(dut3.r_ptr), 32'd2);
    in_valid3 = 3'b100;
    step();
    chk("t4_sel_2", 32'(out_sel3), 32'd2);
    chk("t4_ptr_wrap", 32'(dut3.r_ptr), 32'd0);
    in_valid3 = 3'b001;
    step();
    chk("t4_sel_0", 32'(out_sel3), 32'd0);
    chk("t4_data_0", 32'(out_data3), 32'h20);
    chk("t4_ptr_back", 32'(dut3.r_ptr), 32'd1);
    in_valid3 = 3'b111;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("t4_ptr_range_%0d", i), 32'(dut3.r_ptr < 2'd3), 32'd1);
      chk($sformatf("t4_rr_sel_%0d", i), 32'(out_sel3), 32'((i + 1) % 3));
    end
    in_valid3 = 3'b000;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
